// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side partner of an LFSR pattern generator. It self-synchronises to
// the serial stream (bit = generator state[0] before each shift), then counts
// bit errors while locked and drops lock when too many errors land inside one
// evaluation window.
//
// Parameters
//   WIDTH      LFSR width, 3..9
//   LOCK_COUNT consecutive matches needed to declare lock
//   WINDOW     enabled bits per loss-of-lock evaluation window
//   LOSS_ERRS  errors inside one window that force loss of lock
//   ERR_W      width of the saturating error counter
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   enable     in   bit_in valid this cycle
//   bit_in     in   received serial bit
//   clear      in   synchronous clear of err_count (and bit_count)
//   locked     out  checker synchronised
//   err_pulse  out  one-cycle pulse: previous enabled bit mismatched while locked
//   lock_lost  out  one-cycle pulse on the LOCKED -> SEARCH transition
//   err_count  out  saturating count of errors seen while locked
//   bit_count  out  bits checked while locked (0 unless LFSR_CHK_BITCNT_EN)
//
// Build option
//   LFSR_CHK_BITCNT_EN  when defined, builds the 32-bit saturating bit_count;
//                       otherwise bit_count is tied to zero.
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int WIDTH      = 7,
  parameter int LOCK_COUNT = 16,
  parameter int WINDOW     = 64,
  parameter int LOSS_ERRS  = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      bit_count
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Lead bit of the generator polynomial for the configured width.
  function automatic logic feedback(input logic [WIDTH-1:0] s);
    logic [8:0] e;
    logic       fb;
    e = 9'(s);
    case (WIDTH)
      3:       fb = e[2] ^ e[0];
      4:       fb = e[3] ^ e[0];
      5:       fb = e[4] ^ e[3] ^ e[2] ^ e[0];
      6:       fb = e[5] ^ e[4] ^ e[2] ^ e[1];
      7:       fb = e[6] ^ e[5] ^ e[3] ^ e[0];
      8:       fb = e[7] ^ e[5] ^ e[2] ^ e[1];
      default: fb = e[8] ^ e[6] ^ e[5] ^ e[4] ^ e[3] ^ e[2];
    endcase
    return fb;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   r_q,         r_d;
  logic [FILL_W-1:0]  fill_q,      fill_d;
  logic [MATCH_W-1:0] match_q,     match_d;
  logic [WIN_W-1:0]   win_cnt_q,   win_cnt_d;
  logic [WERR_W-1:0]  win_err_q,   win_err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               locked_q,    locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic               lock_lost_q, lock_lost_d;

  logic              pred;
  logic              mismatch;
  logic              err_evt;
  logic [WERR_W-1:0] win_err_inc;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    err_evt     = 1'b0;
    pred        = feedback(r_q);
    mismatch    = bit_in ^ pred;
    win_err_inc = win_err_q + WERR_W'(mismatch);

    if (enable) begin
      if (state_q == SEARCH) begin
        // Load straight from the stream; comparisons start once r is full.
        r_d = {bit_in, r_q[WIDTH-1:1]};
        if (fill_q != FILL_W'(WIDTH)) begin
          fill_d = fill_q + FILL_W'(1);
        end else if (!mismatch && (r_q != '0)) begin
          if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
            state_d   = LOCKED;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end else begin
          match_d = '0;
        end
      end else begin
        // Free-run on the prediction so a corrupted bit cannot derail r.
        r_d         = {pred, r_q[WIDTH-1:1]};
        err_evt     = mismatch;
        err_pulse_d = mismatch;
        if (win_err_inc >= WERR_W'(LOSS_ERRS)) begin
          state_d     = SEARCH;
          lock_lost_d = 1'b1;
          fill_d      = '0;
          match_d     = '0;
          win_cnt_d   = '0;
          win_err_d   = '0;
        end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          win_err_d = win_err_inc;
        end
      end
    end

    if (clear) begin
      err_count_d = err_evt ? ERR_W'(1) : '0;
    end else if (err_evt) begin
      err_count_d = sat_inc_err(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end

    locked_d = (state_d == LOCKED);
  end

  // Register stage: all outputs appear one cycle after the causing bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      r_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_count_q;

`ifdef LFSR_CHK_BITCNT_EN
  function automatic logic [31:0] sat_inc_bits(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] bit_count_q, bit_count_d;
  logic        bit_evt;

  always_comb begin
    bit_evt = enable && (state_q == LOCKED);
    if (clear) begin
      bit_count_d = bit_evt ? 32'd1 : 32'd0;
    end else if (bit_evt) begin
      bit_count_d = sat_inc_bits(bit_count_q);
    end else begin
      bit_count_d = bit_count_q;
    end
  end

  // Register stage: locked-bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`else
  assign bit_count = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        bit_in;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic        lock_lost;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  lfsr_checker #(
    .WIDTH     (4),
    .LOCK_COUNT(8),
    .WINDOW    (16),
    .LOSS_ERRS (4),
    .ERR_W     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bit_in   (bit_in),
    .clear    (clear),
    .locked   (locked),
    .err_pulse(err_pulse),
    .lock_lost(lock_lost),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

`ifdef LFSR_CHK_BITCNT_EN
  localparam bit BC_ON = 1'b1;
`else
  localparam bit BC_ON = 1'b0;
`endif

  typedef struct {
    int          tag;
    logic        lk;
    logic        ep;
    logic        ll;
    logic [15:0] ec;
    logic        cbc;
    logic [31:0] bc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          tag    = 0;
  int          ph     = 0;
  logic        en_q   = 1'b0;
  // Generator seeded 4'b1000: bit i of this vector is the i-th emitted bit.
  logic [14:0] pat    = 15'b100110101111000;

  task automatic chk(input string nm, input int t, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d got=%0h expected=%0h", nm, t, act, exp);
    end
  endtask

  // Monitor: one expected record per enabled bit, compared half a cycle after
  // the edge that consumed the bit.
  always @(posedge clk) en_q <= enable;

  always @(negedge clk) begin
    if (en_q) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty got=output required=queued expectation");
      end else begin
        mon_e = sbq.pop_front();
        chk("locked",    mon_e.tag, {31'd0, locked},    {31'd0, mon_e.lk});
        chk("err_pulse", mon_e.tag, {31'd0, err_pulse}, {31'd0, mon_e.ep});
        chk("lock_lost", mon_e.tag, {31'd0, lock_lost}, {31'd0, mon_e.ll});
        chk("err_count", mon_e.tag, {16'd0, err_count}, {16'd0, mon_e.ec});
        if (mon_e.cbc) chk("bit_count", mon_e.tag, bit_count, mon_e.bc);
      end
    end
  end

  function automatic logic nb();
    logic b;
    b  = pat[ph];
    ph = (ph + 1) % 15;
    return b;
  endfunction

  task automatic send(input logic b, input logic lk, input logic ep, input logic ll,
                      input int ec, input logic clr, input logic cbc, input int bc);
    exp_t e;
    e.tag = tag; e.lk = lk; e.ep = ep; e.ll = ll;
    e.ec  = 16'(ec); e.cbc = cbc; e.bc = 32'(bc);
    sbq.push_back(e);
    tag++;
    enable = 1'b1;
    bit_in = b;
    clear  = clr;
    @(posedge clk);
    #1;
    clear  = 1'b0;
  endtask

  // n clean bits; locked expected from the lk_from-th bit of this run on.
  task automatic clean(input int n, input int lk_from, input int ec);
    for (int k = 1; k <= n; k++) send(nb(), (k >= lk_from), 1'b0, 1'b0, ec, 1'b0, 1'b0, 0);
  endtask

  task automatic clean_gapped(input int n, input int lk_from);
    for (int k = 1; k <= n; k++) begin
      enable = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(nb(), (k >= lk_from), 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic errb(input logic lk, input logic ll, input int ec);
    send(~nb(), lk, 1'b1, ll, ec, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input int t);
    enable = 1'b0;
    clear  = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("rst_locked",    t, {31'd0, locked},    32'd0);
    chk("rst_err_pulse", t, {31'd0, err_pulse}, 32'd0);
    chk("rst_lock_lost", t, {31'd0, lock_lost}, 32'd0);
    chk("rst_err_count", t, {16'd0, err_count}, 32'd0);
    chk("rst_bit_count", t, bit_count,          32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ph    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    bit_in = 1'b0;
    clear  = 1'b0;
    #12;

    // 1: clean stream locks after the 12th bit
    do_reset(-1);
    clean(20, 12, 0);

    // 2: single error while locked
    errb(1'b1, 1'b0, 1);
    clean(10, 0, 1);

    // 3: four errors in one window lose lock, then relock 12 bits later
    do_reset(-3);
    clean(12, 12, 0);
    errb(1'b1, 1'b0, 1);
    clean(2, 0, 1);
    errb(1'b1, 1'b0, 2);
    clean(2, 0, 2);
    errb(1'b1, 1'b0, 3);
    clean(1, 0, 3);
    errb(1'b0, 1'b1, 4);
    clean(16, 12, 4);

    // 4: three errors at the tail of window A, one at the head of window B
    do_reset(-4);
    clean(12, 12, 0);
    clean(13, 0, 0);
    errb(1'b1, 1'b0, 1);
    errb(1'b1, 1'b0, 2);
    errb(1'b1, 1'b0, 3);
    errb(1'b1, 1'b0, 4);
    clean(5, 0, 4);

    // 5: all-zero input never locks; gapped clean stream; clear vs error
    do_reset(-5);
    for (int k = 0; k < 40; k++) send(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    do_reset(-50);
    ph = 5;
    clean_gapped(20, 12);
    errb(1'b1, 1'b0, 1);
    clean(2, 0, 1);
    send(~nb(), 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 0);
    send(nb(),  1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
    clean(2, 0, 0);

    // 6: bit_count over 30 locked bits, then reset while locked
    do_reset(-6);
    for (int k = 1; k <= 12; k++) send(nb(), (k >= 12), 1'b0, 1'b0, 0, 1'b0, 1'b1, 0);
    for (int k = 1; k <= 30; k++) send(nb(), 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, BC_ON ? k : 0);
    errb(1'b1, 1'b0, 1);
    do_reset(-60);

    enable = 1'b0;
    @(negedge clk);
    #1;
    chk("sb_drained", -7, 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
